apb_poll_master: RTL

APB_POLL_MASTER -- requirements
Module: apb_poll_master

---
 rtl/apb_poll_pkg.sv | 18 +
 rtl/apb_poll_master_if.sv | 26 ++
 rtl/apb_poll_master_xfer.sv | 44 ++++
 rtl/apb_poll_master.sv | 125 ++++++++++++
 4 files changed

// File: rtl/apb_poll_pkg.sv
// Shared types for the APB poll master: FSM state encoding and completion status codes.
package apb_poll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_ACCESS,
        R_SETUP,
        R_ACCESS,
        GAP,
        DONE
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_SLVERR  = 2'b10;

endpackage

// File: rtl/apb_poll_master_if.sv
// APB3/4 bus bundle between the poll master and its slave.
interface apb_poll_master_if #(
    parameter int G_REGWIDTH   = 32,
    parameter int G_ADDR_WIDTH = 7
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [2:0]                pprot;
    logic [G_ADDR_WIDTH-1:0]   paddr;
    logic [G_REGWIDTH-1:0]     pwdata;
    logic [G_REGWIDTH/8-1:0]   pstrb;
    logic                      pready;
    logic [G_REGWIDTH-1:0]     prdata;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_poll_master_xfer.sv
// Single APB transfer engine: i_start marks the setup cycle, access holds until pready.
module apb_xfer #(
    parameter int G_REGWIDTH   = 32,
    parameter int G_ADDR_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_write,
    input  logic [G_ADDR_WIDTH-1:0] i_addr,
    input  logic [G_REGWIDTH-1:0]   i_wdata,
    input  logic [G_REGWIDTH/8-1:0] i_strb,
    output logic                    o_done,
    output logic                    o_err,
    output logic [G_REGWIDTH-1:0]   o_rdata,
    apb_poll_master_if.master       m_apb
);
    logic r_access;
    logic w_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_access <= 1'b0;
        end else if (i_start) begin
            r_access <= 1'b1;
        end else if (r_access && m_apb.pready) begin
            r_access <= 1'b0;
        end
    end

    // Bus is forced idle while reset is high so an aborted transfer drops at once.
    assign w_active      = (i_start || r_access) && !rst;
    assign m_apb.psel    = w_active;
    assign m_apb.penable = r_access && !rst;
    assign m_apb.pwrite  = w_active && i_write;
    assign m_apb.pprot   = '0;
    assign m_apb.paddr   = w_active ? i_addr  : '0;
    assign m_apb.pwdata  = w_active ? i_wdata : '0;
    assign m_apb.pstrb   = w_active ? i_strb  : '0;

    assign o_done  = r_access && m_apb.pready && !rst;
    assign o_err   = m_apb.pslverr;
    assign o_rdata = m_apb.prdata;
endmodule

// File: rtl/apb_poll_master.sv
// Kick-off write followed by masked poll reads until match, slave error or poll limit.
module apb_poll_master
    import apb_poll_pkg::*;
#(
    parameter int G_REGWIDTH   = 32,
    parameter int G_ADDR_WIDTH = 7,
    parameter int G_POLL_GAP   = 2,
    parameter int G_CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [G_ADDR_WIDTH-1:0] cmd_start_addr,
    input  logic [G_REGWIDTH-1:0]   cmd_start_data,
    input  logic [G_ADDR_WIDTH-1:0] cmd_poll_addr,
    input  logic [G_REGWIDTH-1:0]   cmd_poll_mask,
    input  logic [G_REGWIDTH-1:0]   cmd_poll_value,
    input  logic [G_CNT_WIDTH-1:0]  cmd_max_polls,
    output logic                    rsp_valid,
    output logic [1:0]              rsp_status,
    output logic [G_CNT_WIDTH-1:0]  rsp_polls,
    apb_poll_master_if.master       m_apb
);
    localparam int GW = (G_POLL_GAP > 1) ? $clog2(G_POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((G_POLL_GAP > 0) ? G_POLL_GAP - 1 : 0);

    state_t                  r_state, w_state_nxt;
    logic [G_ADDR_WIDTH-1:0] r_start_addr, r_poll_addr;
    logic [G_REGWIDTH-1:0]   r_start_data, r_mask, r_value;
    logic [G_CNT_WIDTH-1:0]  r_limit, r_cnt, w_cnt_inc;
    logic [1:0]              r_status, w_status_nxt;
    logic [GW-1:0]           r_gap;

    logic                    w_accept, w_start, w_write, w_done, w_err, w_match;
    logic [G_REGWIDTH-1:0]   w_rdata;

    assign cmd_ready  = (r_state == IDLE) && !rst;
    assign w_accept   = cmd_valid && cmd_ready;
    assign rsp_valid  = (r_state == DONE) && !rst;
    assign rsp_status = rsp_valid ? r_status : '0;
    assign rsp_polls  = rsp_valid ? r_cnt : '0;

    assign w_start   = (r_state == W_SETUP) || (r_state == R_SETUP);
    assign w_write   = (r_state == W_SETUP) || (r_state == W_ACCESS);
    assign w_match   = (w_rdata & r_mask) == (r_value & r_mask);
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    apb_xfer #(
        .G_REGWIDTH  (G_REGWIDTH),
        .G_ADDR_WIDTH(G_ADDR_WIDTH)
    ) u_xfer (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_start),
        .i_write(w_write),
        .i_addr (w_write ? r_start_addr : r_poll_addr),
        .i_wdata(w_write ? r_start_data : '0),
        .i_strb (w_write ? '1 : '0),
        .o_done (w_done),
        .o_err  (w_err),
        .o_rdata(w_rdata),
        .m_apb  (m_apb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_status <= ST_OK;
            r_gap    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            r_gap    <= (r_state == GAP) ? r_gap + 1'b1 : '0;
            if (w_accept) begin
                r_start_addr <= cmd_start_addr;
                r_start_data <= cmd_start_data;
                r_poll_addr  <= cmd_poll_addr;
                r_mask       <= cmd_poll_mask;
                r_value      <= cmd_poll_value;
                r_limit      <= (cmd_max_polls == '0) ? G_CNT_WIDTH'(1) : cmd_max_polls;
                r_cnt        <= '0;
            end else if (r_state == R_ACCESS && w_done) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        case (r_state)
            IDLE:     if (w_accept) w_state_nxt = W_SETUP;
            W_SETUP:  w_state_nxt = W_ACCESS;
            W_ACCESS: if (w_done) begin
                if (w_err) begin
                    w_state_nxt  = DONE;
                    w_status_nxt = ST_SLVERR;
                end else begin
                    w_state_nxt = R_SETUP;
                end
            end
            R_SETUP:  w_state_nxt = R_ACCESS;
            R_ACCESS: if (w_done) begin
                // Priority: slave error, then match, then limit reached.
                if (w_err) begin
                    w_state_nxt  = DONE;
                    w_status_nxt = ST_SLVERR;
                end else if (w_match) begin
                    w_state_nxt  = DONE;
                    w_status_nxt = ST_OK;
                end else if (w_cnt_inc == r_limit) begin
                    w_state_nxt  = DONE;
                    w_status_nxt = ST_TIMEOUT;
                end else begin
                    w_state_nxt = (G_POLL_GAP == 0) ? R_SETUP : GAP;
                end
            end
            GAP:      if (r_gap == GAP_LAST) w_state_nxt = R_SETUP;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end
endmodule
